trace_cmd_ctrl: RTL



---
 rtl/trace_cmd_pkg.sv | 26 ++
 rtl/tx_frame_arbiter.sv | 60 ++++++
 rtl/trace_cmd_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/trace_cmd_pkg.sv
// Shared command codes, response codes, trace widths and parser states
// for the trace command controller.
package trace_cmd_pkg;

    localparam logic [7:0] CMD_WIDTH  = 8'h57;
    localparam logic [7:0] CMD_ENABLE = 8'h45;
    localparam logic [7:0] CMD_STATUS = 8'h53;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam logic [2:0] WIDTH_1 = 3'd1;
    localparam logic [2:0] WIDTH_2 = 3'd2;
    localparam logic [2:0] WIDTH_4 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_EXEC
    } parse_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WIDTH) || (b == CMD_ENABLE) || (b == CMD_STATUS);
    endfunction

endpackage

// File: rtl/tx_frame_arbiter.sv
// Shares the UART transmitter between trace bytes and command responses,
// inserting responses only on TPIU frame boundaries.
module tx_frame_arbiter
    import trace_cmd_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_free,
    input  logic       trace_en,
    input  logic       trace_avail,
    input  logic [7:0] trace_data,
    input  logic       resp_valid,
    input  logic [7:0] resp_data,
    output logic       tx_transmit,
    output logic [7:0] tx_byte,
    output logic       trace_next,
    output logic       resp_pop
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CW-1:0] frame_cnt;
    logic          last_tx;
    logic          frame_start;
    logic          can_tx;
    logic          send_resp;
    logic          send_trace;

    // Response bytes do not advance the frame counter, so once the first
    // one goes out the second stays eligible and beats any trace byte.
    always_comb begin
        frame_start = (frame_cnt == '0);
        can_tx      = tx_free && !last_tx && !rst;
        send_resp   = can_tx && resp_valid && frame_start;
        send_trace  = can_tx && !send_resp && trace_avail && (trace_en || !frame_start);
        tx_transmit = send_resp || send_trace;
        trace_next  = send_trace;
        resp_pop    = send_resp;
        tx_byte     = 8'h00;
        if (send_resp) begin
            tx_byte = resp_data;
        end else if (send_trace) begin
            tx_byte = trace_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            last_tx   <= 1'b0;
        end else begin
            last_tx <= tx_transmit;
            if (send_trace) begin
                frame_cnt <= (frame_cnt == CW'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_cmd_ctrl.sv
// UART command parser and trace configuration registers; responses are
// queued in a two-byte buffer and drained by the frame-aware arbiter.
module trace_cmd_ctrl
    import trace_cmd_pkg::*;
#(
    parameter int MAX_BUS_WIDTH = 4,
    parameter int FRAME_LEN     = 16,
    parameter int ARG_TIMEOUT   = 48000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_received,
    input  logic       rx_error,
    input  logic       trace_avail,
    input  logic [7:0] trace_data,
    output logic       trace_next,
    input  logic       tx_free,
    output logic       tx_transmit,
    output logic [7:0] tx_byte,
    input  logic       sync,
    input  logic       overflow,
    output logic [2:0] width,
    output logic       trace_en,
    output logic       cmd_err
);
    localparam int TW = $clog2(ARG_TIMEOUT + 1);

    parse_state_t  state, state_next;
    logic [7:0]    cmd;
    logic [TW-1:0] arg_cnt;
    logic [7:0]    resp_head, resp_tail;
    logic [1:0]    resp_cnt;
    logic          resp_valid, resp_pop;
    logic [2:0]    width_q;
    logic          en_q, ovf_sticky, err_q;
    logic          cmd_accept, load, err_next, width_wr, en_wr, ovf_clr;
    logic [7:0]    load_b0, load_b1;

    function automatic logic width_ok(input logic [7:0] arg);
        return ((arg == 8'(WIDTH_1)) || (arg == 8'(WIDTH_2)) || (arg == 8'(WIDTH_4)))
               && (int'(arg) <= MAX_BUS_WIDTH);
    endfunction

    always_comb begin
        state_next = state;
        cmd_accept = 1'b0;
        load       = 1'b0;
        err_next   = 1'b0;
        width_wr   = 1'b0;
        en_wr      = 1'b0;
        ovf_clr    = 1'b0;
        load_b0    = RSP_ACK;
        load_b1    = cmd;
        case (state)
            ST_IDLE: begin
                if (rx_received) begin
                    if (is_cmd(rx_byte)) begin
                        cmd_accept = 1'b1;
                        state_next = ST_ARG;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_ARG: begin
                if (rx_error) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_received) begin
                    load       = 1'b1;
                    state_next = ST_EXEC;
                end else if (arg_cnt == TW'(ARG_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // The parser is busy until the response has fully drained.
                if (rx_received) begin
                    err_next = 1'b1;
                end
                if (resp_cnt == 2'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            case (cmd)
                CMD_WIDTH: begin
                    if (width_ok(rx_byte)) begin
                        width_wr = 1'b1;
                    end else begin
                        load_b0  = RSP_NAK;
                        err_next = 1'b1;
                    end
                end
                CMD_ENABLE: en_wr = 1'b1;
                default: begin
                    load_b0 = CMD_STATUS;
                    load_b1 = {4'b0000, ovf_sticky, sync, en_q, (width_q == WIDTH_4)};
                    ovf_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            arg_cnt    <= '0;
            resp_cnt   <= 2'd0;
            width_q    <= WIDTH_4;
            en_q       <= 1'b1;
            ovf_sticky <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state   <= state_next;
            err_q   <= err_next;
            arg_cnt <= (state == ST_ARG) ? arg_cnt + 1'b1 : '0;
            if (load) begin
                resp_cnt <= 2'd2;
            end else if (resp_pop) begin
                resp_cnt <= resp_cnt - 1'b1;
            end
            if (width_wr) begin
                width_q <= rx_byte[2:0];
            end
            if (en_wr) begin
                en_q <= rx_byte[0];
            end
            // A new overflow wins over the clear from a status read.
            if (overflow) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            cmd <= rx_byte;
        end
        if (load) begin
            resp_head <= load_b0;
            resp_tail <= load_b1;
        end else if (resp_pop) begin
            resp_head <= resp_tail;
        end
    end

    assign resp_valid = (resp_cnt != 2'd0);
    assign width      = width_q;
    assign trace_en   = en_q;
    assign cmd_err    = err_q;

    tx_frame_arbiter #(
        .FRAME_LEN(FRAME_LEN)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .tx_free    (tx_free),
        .trace_en   (en_q),
        .trace_avail(trace_avail),
        .trace_data (trace_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_head),
        .tx_transmit(tx_transmit),
        .tx_byte    (tx_byte),
        .trace_next (trace_next),
        .resp_pop   (resp_pop)
    );

endmodule
